// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: count direction and end-of-range mode.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and end-of-range detect for one count step in direction up.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             at_end
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  // The range end is MAX_VAL, not the all-ones value, so no carry-out is relied on.
  always_comb begin
    at_end = 1'b0;
    nxt    = q;
    if (up == DIR_UP) begin
      at_end = (q == MAX_Q);
      if (at_end) nxt = (SATURATE == MODE_SAT) ? MAX_Q : '0;
      else        nxt = q + WIDTH'(1);
    end else begin
      at_end = (q == '0);
      if (at_end) nxt = (SATURATE == MODE_SAT) ? '0 : MAX_Q;
      else        nxt = q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter over 0..MAX_VAL with preset, clamped load, wrap/saturate ends and overflow pulse.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] nxt;
  logic             at_end;
  logic [WIDTH-1:0] load_val;

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .SATURATE(SATURATE)
  ) u_next (
    .q     (q),
    .up    (up),
    .nxt   (nxt),
    .at_end(at_end)
  );

  assign tc       = en & at_end;
  assign load_val = (data > MAX_Q) ? MAX_Q : data;

  // Priority set > load > en; ovf only follows a real count step taken at the range end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (set) begin
        q <= MAX_Q;
      end else if (load) begin
        q <= load_val;
      end else if (en) begin
        q   <= nxt;
        ovf <= at_end;
      end
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances (wrap 0..9, saturate 0..9, wrap 0..7) against a reference model.
module tb_updown_counter;

  logic clk;
  logic reset_s[3];
  logic set_s[3];
  logic load_s[3];
  logic en_s[3];
  logic up_s[3];
  logic [3:0] data_s[3];

  logic [3:0] q0, q1;
  logic [2:0] q2;
  logic tc0, tc1, tc2;
  logic ovf0, ovf1, ovf2;

  int checks = 0;
  int errors = 0;

  // Reference model state: current count per instance and instance range/mode.
  int mq[3];
  int maxv[3] = '{9, 9, 7};
  int satv[3] = '{0, 1, 0};

  // Expected entry: {instance[1:0], q[3:0], ovf, tc}
  logic [7:0] exp_q[$];

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset_s[0]), .set(set_s[0]), .load(load_s[0]), .data(data_s[0]),
    .en(en_s[0]), .up(up_s[0]), .q(q0), .tc(tc0), .ovf(ovf0)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset_s[1]), .set(set_s[1]), .load(load_s[1]), .data(data_s[1]),
    .en(en_s[1]), .up(up_s[1]), .q(q1), .tc(tc1), .ovf(ovf1)
  );

  updown_counter #(.WIDTH(3), .SATURATE(0)) dut_w3 (
    .clk(clk), .reset(reset_s[2]), .set(set_s[2]), .load(load_s[2]), .data(data_s[2][2:0]),
    .en(en_s[2]), .up(up_s[2]), .q(q2), .tc(tc2), .ovf(ovf2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int get_q(input int idx);
    case (idx)
      0:       return int'(q0);
      1:       return int'(q1);
      default: return int'(q2);
    endcase
  endfunction

  function automatic int get_ovf(input int idx);
    case (idx)
      0:       return int'(ovf0);
      1:       return int'(ovf1);
      default: return int'(ovf2);
    endcase
  endfunction

  function automatic int get_tc(input int idx);
    case (idx)
      0:       return int'(tc0);
      1:       return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  // Apply inputs now and predict the state after the next rising edge.
  task automatic apply(input int idx, input bit s, input bit l, input int d, input bit e, input bit u);
    int dv, nq, novf, ntc;
    logic [1:0] id2;
    logic [3:0] nq4;
    set_s[idx]  = s;
    load_s[idx] = l;
    data_s[idx] = 4'(d);
    en_s[idx]   = e;
    up_s[idx]   = u;
    dv   = (idx == 2) ? (d % 8) : (d % 16);
    novf = 0;
    if (s)                         nq = maxv[idx];
    else if (l)                    nq = (dv > maxv[idx]) ? maxv[idx] : dv;
    else if (!e)                   nq = mq[idx];
    else if (u && mq[idx] == maxv[idx]) begin
      nq = satv[idx] ? maxv[idx] : 0;
      novf = 1;
    end else if (u)                nq = mq[idx] + 1;
    else if (mq[idx] == 0) begin
      nq = satv[idx] ? 0 : maxv[idx];
      novf = 1;
    end else                       nq = mq[idx] - 1;
    ntc = (e && ((u && nq == maxv[idx]) || (!u && nq == 0))) ? 1 : 0;
    mq[idx] = nq;
    id2 = 2'(idx);
    nq4 = 4'(nq);
    exp_q.push_back({id2, nq4, 1'(novf), 1'(ntc)});
  endtask

  task automatic drive(input int idx, input bit s, input bit l, input int d, input bit e, input bit u);
    @(negedge clk);
    apply(idx, s, l, d, e, u);
  endtask

  task automatic idle(input int idx);
    drive(idx, 0, 0, 0, 0, 0);
  endtask

  // Async reset between edges with every control active; release resumes counting up from 0.
  task automatic reset_pulse(input int idx);
    @(negedge clk);
    #2;
    set_s[idx]   = 1'b1;
    load_s[idx]  = 1'b1;
    data_s[idx]  = 4'd5;
    en_s[idx]    = 1'b1;
    up_s[idx]    = 1'b0;
    reset_s[idx] = 1'b0;
    #1;
    check("reset_q_immediate", get_q(idx), 0);
    check("reset_ovf_immediate", get_ovf(idx), 0);
    check("reset_tc_down", get_tc(idx), 1);
    @(posedge clk);
    #1;
    check("reset_ignores_controls", get_q(idx), 0);
    mq[idx] = 0;
    @(negedge clk);
    reset_s[idx] = 1'b1;
    apply(idx, 0, 0, 0, 1, 1);
  endtask

  // Monitor: one prediction is consumed per rising edge it was issued for.
  always @(posedge clk) begin
    logic [7:0] e;
    int idx;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = int'(e[7:6]);
      check($sformatf("q[%0d]", idx), get_q(idx), int'(e[5:2]));
      check($sformatf("ovf[%0d]", idx), get_ovf(idx), int'(e[1]));
      check($sformatf("tc[%0d]", idx), get_tc(idx), int'(e[0]));
    end
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset_s[i] = 1'b0;
      set_s[i]   = 1'b0;
      load_s[i]  = 1'b0;
      en_s[i]    = 1'b0;
      up_s[i]    = 1'b0;
      data_s[i]  = 4'd0;
      mq[i]      = 0;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      check("por_q", get_q(i), 0);
      check("por_ovf", get_ovf(i), 0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) reset_s[i] = 1'b1;

    // Reset mid-count at q=6, then resume up from 0
    drive(0, 0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    reset_pulse(0);
    idle(0);

    // Wrap up through 9 -> 0 -> 1
    drive(0, 0, 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 1);
    // set over load, load clamp, plain load; step-at-end with load gives no ovf
    drive(0, 1, 1, 3, 1, 1);
    drive(0, 0, 1, 15, 1, 1);
    drive(0, 0, 1, 5, 0, 0);
    // Wrap down from 0 to 9, then en=0 with up toggling
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, i % 2 == 0);
    idle(0);

    // Saturating down at 0, then immediate direction change
    drive(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 1);
    // Saturating up at 9
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 1, 1);
    idle(1);

    // WIDTH=3: full up-wrap 0..7,0 and down-wrap 0 -> 7
    drive(2, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(2, 0, 0, 0, 1, 1);
    drive(2, 0, 0, 0, 1, 0);
    idle(2);

    // Randomized traffic on every instance
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 80; n++) begin
        int r;
        r = $urandom_range(0, 99);
        drive(idx, r < 5, (r >= 5) && (r < 15), $urandom_range(0, 15),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end
      idle(idx);
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameters SHALL be one per line as name, default, meaning:
  - WIDTH, 8, counter width in bits (minimum 2).
  - MAX_VAL, 2**WIDTH-1, terminal value; the count range is 0..MAX_VAL, with MAX_VAL <= 2**WIDTH-1.
  - SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends.
REQ-002 Ports SHALL be one per line as name, direction, width, meaning:
  - clk, input, 1, the single clock.
  - reset, input, 1, asynchronous active-low reset.
  - set, input, 1, synchronous preset of q to MAX_VAL.
  - load, input, 1, synchronous parallel load.
  - data, input, WIDTH, load value.
  - en, input, 1, count enable.
  - up, input, 1, count direction: 1 = increment, 0 = decrement.
  - q, output, WIDTH, registered count.
  - tc, output, 1, terminal-count flag (combinational).
  - ovf, output, 1, registered one-cycle range-event pulse.
REQ-003 The block SHALL have exactly one clock, clk; reset SHALL be asynchronous and active-low.

Function
REQ-004 Operations SHALL take effect on the rising edge of clk with priority set > load > en; no operation (all low) holds q.
REQ-005 set=1: q SHALL become MAX_VAL on the next edge, regardless of load, en and data.
REQ-006 load=1 (set=0): q SHALL become data; data > MAX_VAL SHALL be clamped to MAX_VAL.
REQ-007 en=1 with up=1 (set=0, load=0): q SHALL become q+1 when q < MAX_VAL.
REQ-008 Up at q=MAX_VAL: SATURATE=0 -> q SHALL become 0; SATURATE=1 -> q SHALL hold MAX_VAL.
REQ-009 en=1 with up=0: q SHALL become q-1 when q > 0.
REQ-010 Down at q=0: SATURATE=0 -> q SHALL become MAX_VAL; SATURATE=1 -> q SHALL hold 0.
REQ-011 tc SHALL be combinational and equal en AND ((up AND q==MAX_VAL) OR (NOT up AND q==0)).
REQ-012 ovf SHALL be high for exactly the one cycle following any edge on which a count step occurred while tc=1, in either SATURATE mode.
REQ-013 ovf SHALL be 0 after a set or load edge, even if tc was 1 on that edge.
REQ-014 A change of up while en=1 SHALL take effect on the very next edge, with no dead cycle.
REQ-015 Latency from control input to q SHALL be one clock; q SHALL never glitch between edges.
REQ-016 All arithmetic SHALL be WIDTH bits wide, with no dependence on implicit carry-out; range comparisons SHALL use MAX_VAL, not 2**WIDTH-1.

Reset
REQ-017 reset=0 SHALL immediately force q=0 and ovf=0, independent of clk.
REQ-018 While reset=0, set, load and en SHALL be ignored.
REQ-019 Reset deasserted mid-count SHALL resume operation from q=0 on the first edge with reset=1.
REQ-020 tc SHALL reflect the reset q value, so tc=1 during reset if en=1 and up=0.

Structure
REQ-021 A shared package counter_pkg SHALL hold the direction constants (DIR_UP, DIR_DOWN) and the mode constants (MODE_WRAP, MODE_SAT) used by SATURATE.
REQ-022 The next-value and terminal-detect logic SHALL live in one combinational sub-module, counter_next, which computes nxt and at_end from q, up and the parameters.
REQ-023 updown_counter SHALL contain only the priority mux, the q register and the ovf register.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-024 Bench SHALL check: reset=0 mid-count at q=6 -> q=0 and ovf=0 immediately; after release with en=1, up=1 -> q=1 on the first edge.
REQ-025 Bench SHALL check, with SATURATE=0, en=1, up=1 from q=8: q sequence 9, 0, 1; tc=1 while q=9; ovf high for one cycle coinciding with q=0.
REQ-026 Bench SHALL check, with SATURATE=1, en=1, up=0 from q=1: q sequence 0, 0, 0; ovf pulses for each held step; switching to up=1 -> q=1 on the next edge.
REQ-027 Bench SHALL check set=1, load=1, data=3 on one edge -> q=9, then load=1, data=15 -> q=9 (clamped), then load=1, data=5 -> q=5; ovf=0 throughout.
REQ-028 Bench SHALL check, with SATURATE=0, en=1, up=0 from q=0 -> q=9 and ovf=1 on the next cycle; with en=0 and up toggling, q holds and tc=0.
REQ-029 Bench SHALL check, with WIDTH=3 and default MAX_VAL=7, the full up-wrap sequence 0..7,0 and the down-wrap sequence 0,7, with ovf asserted only on the wrap transitions.
